// File: rtl/tdc_hw_accum_if.sv
// rtl/tdc_hw_accum_if.sv - control, sample and result signals of the TDC accumulator
interface tdc_hw_accum_if #(
    parameter int HW_W  = 7,
    parameter int SUM_W = 11
);
    logic             ena;
    logic             start;
    logic             continuous;
    logic             hw_valid;
    logic [HW_W-1:0]  hw;
    logic [1:0]       out_sel;
    logic             busy;
    logic             done;
    logic             ready;
    logic [SUM_W-1:0] sum;
    logic [HW_W-1:0]  mean;
    logic [HW_W-1:0]  hw_min;
    logic [HW_W-1:0]  hw_max;
    logic [7:0]       uo_byte;

    modport master (
        output ena, start, continuous, hw_valid, hw, out_sel,
        input  busy, done, ready, sum, mean, hw_min, hw_max, uo_byte
    );

    modport slave (
        input  ena, start, continuous, hw_valid, hw, out_sel,
        output busy, done, ready, sum, mean, hw_min, hw_max, uo_byte
    );
endinterface

// File: rtl/tdc_hw_accum.sv
// rtl/tdc_hw_accum.sv - multi-sample sum/mean/min/max accumulator for TDC Hamming weights
module tdc_hw_accum #(
    parameter int N           = 64,
    parameter int HW_W        = $clog2(N) + 1,
    parameter int LOG_SAMPLES = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    tdc_hw_accum_if.slave  bus
);
    localparam int SUM_W = HW_W + LOG_SAMPLES;
    localparam int CNT_W = (LOG_SAMPLES > 0) ? LOG_SAMPLES : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'((1 << LOG_SAMPLES) - 1);
    localparam logic [HW_W-1:0]  N_HW = HW_W'(N);

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

    state_t           state_q;
    logic [SUM_W-1:0] acc_q, sum_q;
    logic [CNT_W-1:0] cnt_q;
    logic [HW_W-1:0]  run_min_q, run_max_q, min_q, max_q;
    logic             busy_q, done_q, ready_q;

    logic [HW_W-1:0]  hw_c;
    logic [SUM_W-1:0] acc_d;
    logic [HW_W-1:0]  run_min_d, run_max_d;

    // A hw above N is a bubble artefact; clamp so the sum can never overflow.
    always_comb begin
        hw_c      = (bus.hw > N_HW) ? N_HW : bus.hw;
        acc_d     = acc_q + SUM_W'(hw_c);
        run_min_d = (hw_c < run_min_q) ? hw_c : run_min_q;
        run_max_d = (hw_c > run_max_q) ? hw_c : run_max_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            run_min_q <= '0;
            run_max_q <= '0;
            sum_q     <= '0;
            min_q     <= '0;
            max_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ready_q   <= 1'b0;
        end else if (!bus.ena) begin
            // Abort: partial data is simply abandoned, results and ready are kept.
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        state_q   <= S_ACCUM;
                        busy_q    <= 1'b1;
                        acc_q     <= '0;
                        cnt_q     <= '0;
                        run_min_q <= '1;
                        run_max_q <= '0;
                        ready_q   <= 1'b0;
                    end
                end
                S_ACCUM: begin
                    if (bus.hw_valid) begin
                        acc_q     <= acc_d;
                        run_min_q <= run_min_d;
                        run_max_q <= run_max_d;
                        cnt_q     <= cnt_q + CNT_W'(1);
                        if (cnt_q == LAST) begin
                            state_q <= S_DONE;
                            sum_q   <= acc_d;
                            min_q   <= run_min_d;
                            max_q   <= run_max_d;
                            done_q  <= 1'b1;
                            ready_q <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    done_q <= 1'b0;
                    if (bus.continuous) begin
                        state_q   <= S_ACCUM;
                        acc_q     <= '0;
                        cnt_q     <= '0;
                        run_min_q <= '1;
                        run_max_q <= '0;
                        ready_q   <= 1'b0;
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.ready  = ready_q;
    assign bus.sum    = sum_q;
    assign bus.mean   = sum_q[SUM_W-1:LOG_SAMPLES];
    assign bus.hw_min = min_q;
    assign bus.hw_max = max_q;

    always_comb begin
        bus.uo_byte = 8'd0;
        case (bus.out_sel)
            2'd0:    bus.uo_byte = 8'(sum_q[SUM_W-1:LOG_SAMPLES]);
            2'd1:    bus.uo_byte = 8'(min_q);
            2'd2:    bus.uo_byte = 8'(max_q);
            default: bus.uo_byte = {5'b0, ready_q, busy_q, done_q};
        endcase
    end
endmodule

// File: tb/tb_tdc_hw_accum.sv
// tb/tb_tdc_hw_accum.sv - scoreboard bench for tdc_hw_accum with a sample-list reference model
module tb_tdc_hw_accum;
    localparam int N     = 64;
    localparam int LOG_S = 2;
    localparam int NS    = 1 << LOG_S;
    localparam int HW_W  = 7;
    localparam int SUM_W = HW_W + LOG_S;

    typedef struct {
        int sum;
        int mn;
        int mx;
    } result_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    tdc_hw_accum_if #(.HW_W(HW_W), .SUM_W(SUM_W)) bus ();

    tdc_hw_accum #(.N(N), .HW_W(HW_W), .LOG_SAMPLES(LOG_S)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a measurement is a list of clamped samples; results are
    // computed from the whole list once it holds 2^LOG_S entries.
    int      samples[$];
    result_t exp_q[$];
    bit      m_active, m_done, m_ready;
    int      m_sum, m_min, m_max;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 0; m_done = 0; m_ready = 0;
            m_sum = 0; m_min = 0; m_max = 0;
            samples.delete();
        end else if (!bus.ena) begin
            m_active = 0;
            m_done = 0;
        end else if (m_done) begin
            m_done = 0;
            if (bus.continuous) begin
                m_active = 1; m_ready = 0; samples.delete();
            end else begin
                m_active = 0;
            end
        end else if (m_active) begin
            if (bus.hw_valid) begin
                samples.push_back((int'(bus.hw) > N) ? N : int'(bus.hw));
                if (samples.size() == NS) begin
                    result_t r;
                    r.sum = 0; r.mn = samples[0]; r.mx = samples[0];
                    foreach (samples[i]) begin
                        r.sum += samples[i];
                        if (samples[i] < r.mn) r.mn = samples[i];
                        if (samples[i] > r.mx) r.mx = samples[i];
                    end
                    exp_q.push_back(r);
                    m_sum = r.sum; m_min = r.mn; m_max = r.mx;
                    m_active = 0; m_done = 1; m_ready = 1;
                end
            end
        end else if (bus.start) begin
            m_active = 1; m_ready = 0; samples.delete();
        end
    end

    // Monitor: status every cycle, full result record whenever done is presented.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy", bus.busy, m_active || m_done);
            chk("ready", bus.ready, m_ready);
            chk("done", bus.done, m_done);
            chk("sum_held", bus.sum, m_sum);
            if (bus.done) begin
                if (exp_q.size() == 0) begin
                    chk("done_unexpected", 1, 0);
                end else begin
                    result_t r;
                    r = exp_q.pop_front();
                    chk("sb_sum", bus.sum, r.sum);
                    chk("sb_mean", bus.mean, r.sum >> LOG_S);
                    chk("sb_min", bus.hw_min, r.mn);
                    chk("sb_max", bus.hw_max, r.mx);
                end
            end
        end
    end

    task automatic strobe(input int v);
        @(negedge clk);
        bus.hw_valid = 1'b1;
        bus.hw = 7'(v);
        @(negedge clk);
        bus.hw_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (bus.busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy) chk("idle_timeout", 0, 1);
    endtask

    initial begin
        int last_done, dones, sel;
        logic [7:0] exp_b;
        bus.ena = 1'b1; bus.start = 1'b0; bus.continuous = 1'b0;
        bus.hw_valid = 1'b0; bus.hw = '0; bus.out_sel = 2'd0;

        // Reset state
        #12;
        chk("rst_busy", bus.busy, 0);
        chk("rst_sum", bus.sum, 0);
        chk("rst_uo", bus.uo_byte, 0);
        @(negedge clk); #2 rst_n = 1'b1;

        // Single shot; coincident strobe excluded, start held while busy ignored
        @(negedge clk);
        bus.start = 1'b1; bus.hw_valid = 1'b1; bus.hw = 7'd50;
        @(negedge clk);
        bus.hw_valid = 1'b0;
        strobe(10);
        @(negedge clk);
        strobe(20);
        bus.start = 1'b0;
        @(negedge clk);
        strobe(30);
        @(negedge clk); @(negedge clk);
        strobe(41);
        chk("t1_done_latency", bus.done, 1);
        chk("t1_sum", bus.sum, 101);
        chk("t1_mean", bus.mean, 25);
        chk("t1_min", bus.hw_min, 10);
        chk("t1_max", bus.hw_max, 41);
        @(negedge clk);
        chk("t1_busy", bus.busy, 0);
        chk("t1_ready", bus.ready, 1);
        for (int s = 0; s < 4; s++) begin
            bus.out_sel = 2'(s);
            #1;
            case (s)
                0: exp_b = 8'd25;
                1: exp_b = 8'd10;
                2: exp_b = 8'd41;
                default: exp_b = 8'b0000_0100;
            endcase
            chk("t1_uo_byte", bus.uo_byte, exp_b);
        end

        // Clamp
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        for (int i = 0; i < NS; i++) strobe(127);
        chk("clamp_sum", bus.sum, 256);
        chk("clamp_max", bus.hw_max, 64);

        // Continuous, back-to-back strobes
        @(negedge clk);
        bus.continuous = 1'b1; bus.start = 1'b1; bus.hw_valid = 1'b1; bus.hw = 7'd64;
        @(negedge clk); bus.start = 1'b0;
        last_done = -1; dones = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (bus.done) begin
                if (last_done >= 0) chk("cont_period", c - last_done, 5);
                last_done = c;
                dones++;
                chk("cont_sum", bus.sum, 256);
            end
        end
        chk("cont_done_count", dones >= 5, 1);
        bus.continuous = 1'b0;
        wait_idle(20);
        bus.hw_valid = 1'b0;

        // Abort after two samples
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        strobe(5); strobe(6);
        bus.ena = 1'b0;
        @(negedge clk); bus.ena = 1'b1;
        chk("abort_busy", bus.busy, 0);
        chk("abort_sum", bus.sum, 256);
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        strobe(1); strobe(2); strobe(3);
        chk("abort_no_early_done", bus.done, 0);
        strobe(4);
        chk("abort_full_sum", bus.sum, 10);

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            bus.ena        = ($urandom_range(0, 19) != 0);
            bus.start      = ($urandom_range(0, 3) == 0);
            bus.continuous = 1'($urandom_range(0, 1));
            bus.hw_valid   = 1'($urandom_range(0, 1));
            bus.hw         = 7'($urandom_range(0, 127));
            sel            = $urandom_range(0, 3);
            bus.out_sel    = 2'(sel);
            #1;
            case (sel)
                0: exp_b = 8'(m_sum >> LOG_S);
                1: exp_b = 8'(m_min);
                2: exp_b = 8'(m_max);
                default: exp_b = {5'b0, m_ready, m_active || m_done, m_done};
            endcase
            chk("rand_uo_byte", bus.uo_byte, exp_b);
        end
        bus.ena = 1'b0; bus.start = 1'b0; bus.hw_valid = 1'b0; bus.continuous = 1'b0;
        @(negedge clk); bus.ena = 1'b1;

        // Asynchronous reset mid-accumulation
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        strobe(9);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", bus.busy, 0);
        chk("arst_ready", bus.ready, 0);
        chk("arst_sum", bus.sum, 0);
        chk("arst_min", bus.hw_min, 0);
        chk("arst_max", bus.hw_max, 0);
        bus.out_sel = 2'd0; #1;
        chk("arst_uo", bus.uo_byte, 0);
        @(negedge clk); #2 rst_n = 1'b1;
        @(negedge clk); @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tdc_hw_accum.md
# tdc_hw_accum

Multi-sample measurement controller for the delay-line TDC. It accepts the synchronised Hamming-weight (hw) result of each TDC capture and accumulates 2^LOG_SAMPLES samples per measurement. It reports sum, truncated mean, minimum and maximum, and supports single-shot or continuous operation. It sits between `tdc_top` and the pin-limited top level; an 8-bit readout mux lets one output byte carry any result.

## Interface
Parameters:
- N, 64: delay-line length in taps; legal range 2..128.
- HW_W, $clog2(N)+1: hw width (7 for N=64); must be ≤ 8.
- LOG_SAMPLES, 4: log2 of samples per measurement; legal range 0..8.
- SUM_W, HW_W+LOG_SAMPLES: accumulator width (derived, not overridable).

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- ena  in  1  block enable; low aborts any measurement.
- start  in  1  begin a measurement; one-cycle pulse or level.
- continuous  in  1  1 = restart automatically after each measurement.
- hw_valid  in  1  one-cycle strobe, already synchronous to clk; hw is valid.
- hw  in  HW_W  TDC Hamming weight.
- out_sel  in  2  readout select.
- busy  out  1  measurement in progress.
- done  out  1  one-cycle pulse when results update.
- ready  out  1  sticky; results valid since the last start.
- sum  out  SUM_W  sum of the last completed measurement.
- mean  out  HW_W  sum >> LOG_SAMPLES (truncating).
- hw_min  out  HW_W  minimum sample of the last completed measurement.
- hw_max  out  HW_W  maximum sample of the last completed measurement.
- uo_byte  out  8  readout mux, zero-extended.

## Operation
- Reset values: state IDLE; all other outputs 0. Internal accumulator, sample counter, min and max are also cleared.
- States: IDLE, ACCUM, DONE.
- IDLE → ACCUM when start=1 and ena=1. On entry: clear accumulator and sample counter, clear ready, load running-min with all-ones and running-max with 0.
- ACCUM, on each hw_valid:
  - Clamp the sample: hw_c = (hw > N) ? N : hw.
  - acc += hw_c; update running min/max; count++.
- ACCUM → DONE when the 2^LOG_SAMPLES-th sample is accepted. In the same edge, sum, mean, hw_min and hw_max load from the final values, including that last sample.
- DONE lasts one cycle: done=1, ready set.
  - Then → ACCUM (re-initialised as above) if continuous=1 and ena=1.
  - Otherwise → IDLE.
- busy = 1 in ACCUM and DONE.
- start while busy: ignored. There is no restart mid-measurement.
- ena=0 in any state: → IDLE on the next edge. Accumulated partial data is discarded. Result outputs and ready are held; no done pulse.
- Result registers change only in the ACCUM→DONE edge and on reset.
- Width rule: SUM_W bits cannot overflow, since the maximum is N·2^LOG_SAMPLES. Mean is sum[SUM_W-1:LOG_SAMPLES]. With LOG_SAMPLES=0, mean = sum = the single sample.
- uo_byte by out_sel:
  - 0: mean.
  - 1: hw_min.
  - 2: hw_max.
  - 3: {5'b0, ready, busy, done}.

## Timing
- start sampled at edge k → state ACCUM from k+1.
- An hw_valid coincident with the accepting start edge is not counted. Counting starts with strobes sampled from edge k+1.
- Results and done appear one cycle after the final hw_valid edge.
- Continuous mode:
  - A strobe arriving during the DONE cycle is dropped.
  - The next measurement counts strobes from the cycle after DONE.
  - Minimum turnaround between measurements is one cycle.
- hw_valid strobes on consecutive cycles are all accepted (one sample/cycle throughput).
- uo_byte is combinational from registered results and out_sel.
- Async reset mid-ACCUM returns every output to 0 immediately, independent of clk.

## Test plan
- Single-shot, LOG_SAMPLES=2, N=64: start, then hw 10,20,30,41 with gaps. Required: done pulse once one cycle after the 41 strobe; sum=101, mean=25, min=10, max=41, ready=1, busy=0.
- Same measurement, out_sel stepped 0,1,2,3. Required: uo_byte=25, 10, 41, 8'b0000_0100.
- Back-to-back strobes, continuous=1, LOG_SAMPLES=2:
  - hw=64 on every cycle. Required: done every 5 cycles, sum=256, mean=64, min=max=64.
  - Strobes that fall in DONE cycles are not counted.
- Clamp: hw=127 with N=64, all four samples. Required: sum=256, max=64.
- Abort: after 2 of 4 samples, drop ena for one cycle. Required: state IDLE, busy=0, no done, prior results unchanged. A new start then needs a full 4 samples.
- Reset and edge cases:
  - rst_n low mid-ACCUM → all outputs 0 asynchronously.
  - start with a coincident hw_valid → that sample excluded from the sum.
  - start asserted while busy → no effect on count.
